plru_replacement: RTL and testbench

- Tree pseudo-LRU replacement tracker for the L2 cache model.
- Sits directly downstream of the way encoder and consumes its way index on every lookup.
- Keeps one PLRU tree per set. On a hit it marks the hit way as recently used. On a miss it returns the victim way, then marks that way as used.
- Includes a sequential flush sweep that clears every tree.

---
 rtl/cache_pkg.sv | 16 +
 rtl/plru_tree_logic.sv | 46 ++++
 rtl/plru_replacement.sv | 123 ++++++++++++
 tb/tb_plru_replacement.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared cache types and defaults for the L2 PLRU replacement tracker.
// Holds the default geometry, index typedefs and the tracker FSM states.
package cache_pkg;

  localparam int WAYS_DEF = 8;
  localparam int SETS_DEF = 16;

  typedef logic [$clog2(WAYS_DEF)-1:0] way_idx_t;
  typedef logic [$clog2(SETS_DEF)-1:0] set_idx_t;

  typedef enum logic {
    IDLE,
    FLUSH
  } plru_state_e;

endpackage

// File: rtl/plru_tree_logic.sv
// Combinational tree-PLRU walk: picks the victim leaf and computes the
// updated tree bits after touching the hit way or the victim.
module plru_tree_logic #(
  parameter int  WAYS = 8,
  localparam int WW   = $clog2(WAYS),
  localparam int NB   = WAYS - 1
) (
  input  logic [NB-1:0] tree,
  input  logic          hit,
  input  logic [WW-1:0] way,
  output logic [WW-1:0] touched,
  output logic [NB-1:0] tree_next
);

  localparam logic [WW-1:0] ONE = WW'(1);

  logic [WW-1:0] victim;
  logic [WW-1:0] nv;
  logic [WW-1:0] nu;
  logic          b;

  // Follow the tree bits from the root down to the least recently used leaf
  always_comb begin
    victim = '0;
    nv     = '0;
    for (int l = 0; l < WW; l++) begin
      victim[WW-1-l] = tree[nv];
      nv = (nv << 1) + ONE + (tree[nv] ? ONE : '0);
    end
  end

  assign touched = hit ? way : victim;

  // Point every node on the touched way's path away from that way
  always_comb begin
    tree_next = tree;
    nu        = '0;
    b         = 1'b0;
    for (int l = 0; l < WW; l++) begin
      b = touched[WW-1-l];
      tree_next[nu] = ~b;
      nu = (nu << 1) + ONE + (b ? ONE : '0);
    end
  end

endmodule

// File: rtl/plru_replacement.sv
// Per-set tree pseudo-LRU tracker with a sequential flush sweep.
// Optional PLRU_STATS_EN adds saturating hit/miss counters.
module plru_replacement
  import cache_pkg::*;
#(
  parameter int  WAYS = WAYS_DEF,
  parameter int  SETS = SETS_DEF,
  localparam int WW   = $clog2(WAYS),
  localparam int SW   = $clog2(SETS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          acc_valid,
  output logic          acc_ready,
  input  logic [SW-1:0] acc_set,
  input  logic          acc_hit,
  input  logic [WW-1:0] acc_way,
  input  logic          flush_req,
  output logic          busy,
  output logic          rsp_valid,
  output logic          rsp_hit,
  output logic [WW-1:0] rsp_way
`ifdef PLRU_STATS_EN
  ,
  output logic [31:0]   hit_count,
  output logic [31:0]   miss_count
`endif
);

  localparam int NB = WAYS - 1;
  localparam logic [SW-1:0] LAST = SW'(SETS - 1);

  logic [NB-1:0] tree [SETS];
  plru_state_e   state;
  plru_state_e   state_nx;
  logic [SW-1:0] ptr;
  logic          accept;
  logic [NB-1:0] cur;
  logic [NB-1:0] nxt;
  logic [WW-1:0] touched;

  assign accept = acc_valid && acc_ready;
  assign cur    = tree[acc_set];

  plru_tree_logic #(.WAYS(WAYS)) u_tree (
    .tree      (cur),
    .hit       (acc_hit),
    .way       (acc_way),
    .touched   (touched),
    .tree_next (nxt)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // FSM next state: flush sweeps once, later requests are ignored
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (flush_req) state_nx = FLUSH;
      FLUSH:   if (ptr == LAST) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    acc_ready = (state == IDLE);
    busy      = (state == FLUSH);
  end

  // Sweep pointer, parked at zero while idle
  always_ff @(posedge clk) begin
    if (rst)                ptr <= '0;
    else if (state == IDLE) ptr <= '0;
    else                    ptr <= ptr + SW'(1);
  end

  // Tree storage: bulk clear on reset, one set per cycle on flush
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SETS; i++) tree[i] <= '0;
    end else if (state == FLUSH) begin
      tree[ptr] <= '0;
    end else if (accept) begin
      tree[acc_set] <= nxt;
    end
  end

  // Response registers, one cycle after acceptance
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_hit   <= 1'b0;
      rsp_way   <= '0;
    end else begin
      rsp_valid <= accept;
      if (accept) begin
        rsp_hit <= acc_hit;
        rsp_way <= touched;
      end
    end
  end

`ifdef PLRU_STATS_EN
  // Saturating hit/miss counters, untouched by flush
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (accept) begin
      if (acc_hit && hit_count != '1)
        hit_count <= hit_count + 32'd1;
      if (!acc_hit && miss_count != '1)
        miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_plru_replacement.sv
// Directed self-checking bench for plru_replacement.
module tb_plru_replacement;
  import cache_pkg::*;

  logic     clk = 1'b0;
  logic     rst = 1'b1;
  logic     acc_valid = 1'b0;
  logic     acc_ready;
  set_idx_t acc_set = '0;
  logic     acc_hit = 1'b0;
  way_idx_t acc_way = '0;
  logic     flush_req = 1'b0;
  logic     busy;
  logic     rsp_valid;
  logic     rsp_hit;
  way_idx_t rsp_way;
`ifdef PLRU_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  plru_replacement dut (
    .clk       (clk),
    .rst       (rst),
    .acc_valid (acc_valid),
    .acc_ready (acc_ready),
    .acc_set   (acc_set),
    .acc_hit   (acc_hit),
    .acc_way   (acc_way),
    .flush_req (flush_req),
    .busy      (busy),
    .rsp_valid (rsp_valid),
    .rsp_hit   (rsp_hit),
    .rsp_way   (rsp_way)
`ifdef PLRU_STATS_EN
    ,
    .hit_count (hit_count),
    .miss_count(miss_count)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    acc_valid = 1'b0;
    flush_req = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // present one lookup, then check the response one cycle later
  task automatic look(input string tag, input int s, input logic h,
                      input int w, input int exp_way);
    acc_valid = 1'b1;
    acc_set = set_idx_t'(s);
    acc_hit = h;
    acc_way = way_idx_t'(w);
    tick();
    check({tag, "_valid"}, 32'(rsp_valid), 32'd1);
    check({tag, "_hit"}, 32'(rsp_hit), 32'(h));
    check({tag, "_way"}, 32'(rsp_way), 32'(exp_way));
  endtask

  task automatic idle();
    acc_valid = 1'b0;
    tick();
  endtask

  int seq8 [8] = '{0, 4, 2, 6, 1, 5, 3, 7};
  int n;

  initial begin
    do_reset();
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_hit", 32'(rsp_hit), 32'd0);
    check("rst_rsp_way", 32'(rsp_way), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(acc_ready), 32'd1);

    for (int i = 0; i < 8; i++) look($sformatf("miss3_%0d", i), 3, 1'b0, 0, seq8[i]);
    look("miss3_wrap", 3, 1'b0, 0, 0);
    idle();
    check("pulse_end", 32'(rsp_valid), 32'd0);

    do_reset();
    look("hit0_w0", 0, 1'b1, 0, 0);
    idle();
    check("tree0_bits", 32'(dut.tree[0]), 32'h0b);
    look("miss0_after_hit", 0, 1'b0, 0, 4);

    look("alt_s1_a", 1, 1'b0, 0, 0);
    look("alt_s2_a", 2, 1'b0, 0, 0);
    look("alt_s1_b", 1, 1'b0, 0, 4);
    look("alt_s2_b", 2, 1'b0, 0, 4);

    look("s5_a", 5, 1'b0, 0, 0);
    look("s5_b", 5, 1'b0, 0, 4);
    look("s5_c", 5, 1'b0, 0, 2);
    acc_valid = 1'b0;
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    acc_valid = 1'b1;
    acc_set = set_idx_t'(5);
    acc_hit = 1'b0;
    for (int i = 0; i < 16; i++) begin
      check($sformatf("fl_busy_%0d", i), 32'(busy), 32'd1);
      check($sformatf("fl_ready_%0d", i), 32'(acc_ready), 32'd0);
      check($sformatf("fl_norsp_%0d", i), 32'(rsp_valid), 32'd0);
      if (i == 3) flush_req = 1'b1;
      if (i == 4) flush_req = 1'b0;
      tick();
    end
    check("fl_done_busy", 32'(busy), 32'd0);
    check("fl_done_ready", 32'(acc_ready), 32'd1);
    check("fl_done_norsp", 32'(rsp_valid), 32'd0);
    look("s5_after_flush", 5, 1'b0, 0, 0);
    idle();
    check("no_restart", 32'(busy), 32'd0);

    acc_valid = 1'b1;
    acc_set = set_idx_t'(7);
    acc_hit = 1'b0;
    flush_req = 1'b1;
    tick();
    acc_valid = 1'b0;
    flush_req = 1'b0;
    check("sim_valid", 32'(rsp_valid), 32'd1);
    check("sim_way", 32'(rsp_way), 32'd0);
    check("sim_busy", 32'(busy), 32'd1);
    n = 0;
    while (busy && n < 40) begin
      tick();
      n++;
    end
    check("sim_flush_len", 32'(n), 32'd16);
    look("s7_after_flush", 7, 1'b0, 0, 0);
    idle();

`ifdef PLRU_STATS_EN
    do_reset();
    check("st_rst_hit", hit_count, 32'd0);
    for (int i = 0; i < 5; i++) look($sformatf("st_hit_%0d", i), 9, 1'b1, i, i);
    look("st_miss_0", 10, 1'b0, 0, 0);
    look("st_miss_1", 10, 1'b0, 0, 4);
    look("st_miss_2", 10, 1'b0, 0, 2);
    idle();
    check("st_hits", hit_count, 32'd5);
    check("st_misses", miss_count, 32'd3);
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    for (int i = 0; i < 17; i++) tick();
    check("st_flush_hits", hit_count, 32'd5);
    check("st_flush_misses", miss_count, 32'd3);
    do_reset();
    check("st_rst_hits", hit_count, 32'd0);
    check("st_rst_misses", miss_count, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
